mem_port_arbiter: RTL

Sequencer that shares the single data/fetch memory model between the instruction-fetch requester and the load/store requester of one hart. It arbitrates round-robin, drives the memory's fetch, read and write address ports from registered requests, and returns one-cycle response pulses. Byte, half-word and word stores are carried out as aligned 64-bit read-modify-write sequences, because the memory accepts only whole 64-bit writes. The block sits between the core pipeline and the memory model.

---
 rtl/mem_arbiter_pkg.sv | 45 ++++
 rtl/store_lane_merge.sv | 22 ++
 rtl/mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the fetch/load-store memory port arbiter.
package mem_arbiter_pkg;

    localparam int unsigned WORD_BYTES = 8;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;
    localparam logic [1:0] SIZE_D = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_LOAD      = 3'd2,
        ST_STORE     = 3'd3,
        ST_RMW_READ  = 3'd4,
        ST_RMW_WRITE = 3'd5,
        ST_FAULT     = 3'd6
    } state_e;

    // Right-justified byte-lane mask covering one access of the given size.
    function automatic logic [63:0] size_mask(input logic [1:0] size);
        logic [63:0] m;
        case (size)
            SIZE_B:  m = 64'h0000_0000_0000_00ff;
            SIZE_H:  m = 64'h0000_0000_0000_ffff;
            SIZE_W:  m = 64'h0000_0000_ffff_ffff;
            default: m = 64'hffff_ffff_ffff_ffff;
        endcase
        return m;
    endfunction

    // Low address bits that must be zero for a naturally aligned access.
    function automatic logic [2:0] align_mask(input logic [1:0] size);
        logic [2:0] m;
        case (size)
            SIZE_B:  m = 3'b000;
            SIZE_H:  m = 3'b001;
            SIZE_W:  m = 3'b011;
            default: m = 3'b111;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/store_lane_merge.sv
// Replaces the byte lanes of a doubleword selected by size and offset with
// the right-justified write data.
module store_lane_merge
    import mem_arbiter_pkg::*;
(
    input  logic [63:0] old_dw_i,
    input  logic [63:0] wdata_i,
    input  logic [1:0]  size_i,
    input  logic [2:0]  offset_i,
    output logic [63:0] merged_o
);

    logic [5:0]  shamt;
    logic [63:0] base_mask;
    logic [63:0] lane_mask;

    assign shamt     = {offset_i, 3'b000};
    assign base_mask = size_mask(size_i);
    assign lane_mask = base_mask << shamt;
    assign merged_o  = (old_dw_i & ~lane_mask) | ((wdata_i & base_mask) << shamt);

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sequencer sharing one memory model between instruction fetch
// and load/store; sub-doubleword stores become read-modify-write sequences.
module mem_port_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 64,
    parameter int unsigned FETCH_W = 32,
    parameter int unsigned DATA_W  = 64
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [ADDR_W-1:0] fetch_req_addr,
    output logic              fetch_resp_valid,
    output logic [FETCH_W-1:0] fetch_resp_data,
    output logic              fetch_resp_exception,

    input  logic              data_req_valid,
    output logic              data_req_ready,
    input  logic              data_req_write,
    input  logic [1:0]        data_req_size,
    input  logic [ADDR_W-1:0] data_req_addr,
    input  logic [DATA_W-1:0] data_req_wdata,
    output logic              data_resp_valid,
    output logic [DATA_W-1:0] data_resp_data,
    output logic              data_resp_exception,

    output logic              mem_fetch_enable,
    output logic              mem_write_enable,
    output logic [ADDR_W-1:0] mem_fetch_address,
    output logic [ADDR_W-1:0] mem_read_address,
    output logic [ADDR_W-1:0] mem_write_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [FETCH_W-1:0] mem_fetch_data,
    input  logic [DATA_W-1:0] mem_read_data,
    input  logic              mem_fetch_exception,
    input  logic              mem_read_exception,
    input  logic              mem_write_exception
);

    localparam int unsigned OFF_W = $clog2(WORD_BYTES);

    state_e               state_q, state_d;
    logic                 last_grant_data_q, last_grant_data_d;
    logic                 is_fetch_q, is_fetch_d;
    logic [ADDR_W-1:0]    addr_q, addr_d;
    logic [1:0]           size_q, size_d;
    logic [DATA_W-1:0]    wdata_q, wdata_d;
    logic [DATA_W-1:0]    wr_data_q, wr_data_d;
    logic                 f_valid_q, f_valid_d;
    logic [FETCH_W-1:0]   f_data_q, f_data_d;
    logic                 f_exc_q, f_exc_d;
    logic                 d_valid_q, d_valid_d;
    logic [DATA_W-1:0]    d_data_q, d_data_d;
    logic                 d_exc_q, d_exc_d;

    logic                 grant_fetch;
    logic                 grant_data;
    logic                 fetch_misaligned;
    logic                 data_misaligned;
    logic [2:0]           off;
    logic [ADDR_W-1:0]    aligned_addr;
    logic [DATA_W-1:0]    load_data;
    logic [DATA_W-1:0]    merged_dw;
    logic                 in_idle;
    logic                 in_write;

    // Fetch wins a tie unless it was granted last time.
    assign grant_fetch = fetch_req_valid && (!data_req_valid || last_grant_data_q);
    assign grant_data  = data_req_valid && (!fetch_req_valid || !last_grant_data_q);

    assign fetch_misaligned = |fetch_req_addr[1:0];
    assign data_misaligned  = |(data_req_addr[2:0] & align_mask(data_req_size));

    assign off          = addr_q[OFF_W-1:0];
    assign aligned_addr = {addr_q[ADDR_W-1:OFF_W], OFF_W'(0)};
    assign load_data    = DATA_W'((mem_read_data >> {off, 3'b000}) & size_mask(size_q));

    store_lane_merge u_merge (
        .old_dw_i (mem_read_data),
        .wdata_i  (wdata_q),
        .size_i   (size_q),
        .offset_i (off),
        .merged_o (merged_dw)
    );

    // Readies are gated by reset so every output reads 0 while it is held.
    assign in_idle         = (state_q == ST_IDLE) && reset;
    assign fetch_req_ready = in_idle && grant_fetch;
    assign data_req_ready  = in_idle && grant_data;

    assign in_write          = (state_q == ST_STORE) || (state_q == ST_RMW_WRITE);
    assign mem_fetch_enable  = (state_q == ST_FETCH);
    assign mem_fetch_address = (state_q == ST_FETCH) ? addr_q : '0;
    assign mem_read_address  = ((state_q == ST_LOAD) || (state_q == ST_RMW_READ)) ? aligned_addr : '0;
    assign mem_write_address = in_write ? aligned_addr : '0;
    assign mem_write_enable  = in_write && !mem_write_exception;
    assign mem_write_data    = wr_data_q;

    assign fetch_resp_valid     = f_valid_q;
    assign fetch_resp_data      = f_data_q;
    assign fetch_resp_exception = f_exc_q;
    assign data_resp_valid      = d_valid_q;
    assign data_resp_data       = d_data_q;
    assign data_resp_exception  = d_exc_q;

    // Next-state and registered response logic.
    always_comb begin
        state_d           = state_q;
        last_grant_data_d = last_grant_data_q;
        is_fetch_d        = is_fetch_q;
        addr_d            = addr_q;
        size_d            = size_q;
        wdata_d           = wdata_q;
        wr_data_d         = wr_data_q;
        f_valid_d         = 1'b0;
        f_data_d          = f_data_q;
        f_exc_d           = f_exc_q;
        d_valid_d         = 1'b0;
        d_data_d          = d_data_q;
        d_exc_d           = d_exc_q;

        case (state_q)
            ST_IDLE: begin
                if (grant_fetch) begin
                    addr_d            = fetch_req_addr;
                    is_fetch_d        = 1'b1;
                    last_grant_data_d = 1'b0;
                    state_d           = fetch_misaligned ? ST_FAULT : ST_FETCH;
                end else if (grant_data) begin
                    addr_d            = data_req_addr;
                    size_d            = data_req_size;
                    wdata_d           = data_req_wdata;
                    is_fetch_d        = 1'b0;
                    last_grant_data_d = 1'b1;
                    if (data_misaligned) begin
                        state_d = ST_FAULT;
                    end else if (!data_req_write) begin
                        state_d = ST_LOAD;
                    end else if (data_req_size == SIZE_D) begin
                        state_d   = ST_STORE;
                        wr_data_d = data_req_wdata;
                    end else begin
                        state_d = ST_RMW_READ;
                    end
                end
            end
            ST_FETCH: begin
                f_valid_d = 1'b1;
                f_data_d  = mem_fetch_data;
                f_exc_d   = mem_fetch_exception;
                state_d   = ST_IDLE;
            end
            ST_LOAD: begin
                d_valid_d = 1'b1;
                d_data_d  = load_data;
                d_exc_d   = mem_read_exception;
                state_d   = ST_IDLE;
            end
            ST_RMW_READ: begin
                if (mem_read_exception) begin
                    d_valid_d = 1'b1;
                    d_data_d  = '0;
                    d_exc_d   = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wr_data_d = merged_dw;
                    state_d   = ST_RMW_WRITE;
                end
            end
            ST_STORE, ST_RMW_WRITE: begin
                d_valid_d = 1'b1;
                d_data_d  = '0;
                d_exc_d   = mem_write_exception;
                state_d   = ST_IDLE;
            end
            ST_FAULT: begin
                if (is_fetch_q) begin
                    f_valid_d = 1'b1;
                    f_data_d  = '0;
                    f_exc_d   = 1'b1;
                end else begin
                    d_valid_d = 1'b1;
                    d_data_d  = '0;
                    d_exc_d   = 1'b1;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q           <= ST_IDLE;
            last_grant_data_q <= 1'b1;
            is_fetch_q        <= 1'b0;
            addr_q            <= '0;
            size_q            <= '0;
            wdata_q           <= '0;
            wr_data_q         <= '0;
            f_valid_q         <= 1'b0;
            f_data_q          <= '0;
            f_exc_q           <= 1'b0;
            d_valid_q         <= 1'b0;
            d_data_q          <= '0;
            d_exc_q           <= 1'b0;
        end else begin
            state_q           <= state_d;
            last_grant_data_q <= last_grant_data_d;
            is_fetch_q        <= is_fetch_d;
            addr_q            <= addr_d;
            size_q            <= size_d;
            wdata_q           <= wdata_d;
            wr_data_q         <= wr_data_d;
            f_valid_q         <= f_valid_d;
            f_data_q          <= f_data_d;
            f_exc_q           <= f_exc_d;
            d_valid_q         <= d_valid_d;
            d_data_q          <= d_data_d;
            d_exc_q           <= d_exc_d;
        end
    end

endmodule
